// File: rtl/am2946_ctl_if.sv
// Request/grant and transceiver-control bundle between the two bus masters
// and the am2946 direction controller.
interface am2946_ctl_if;
    logic reqa;
    logic reqb;
    logic gnta;
    logic gntb;
    logic cd;
    logic tr_;
    logic busy;

    modport master (
        output reqa,
        output reqb,
        input  gnta,
        input  gntb,
        input  cd,
        input  tr_,
        input  busy
    );

    modport slave (
        input  reqa,
        input  reqb,
        output gnta,
        output gntb,
        output cd,
        output tr_,
        output busy
    );
endinterface

// File: rtl/am2946_ctl.sv
// Arbitrates A/B bus masters over an inverting transceiver pair so that the
// direction line only moves while the transceiver is disabled.
module am2946_ctl #(
    parameter int unsigned TURN    = 2,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    am2946_ctl_if.slave bus
);

    localparam int HW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAXHOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
    localparam logic [3:0]    TURN_LOAD = 4'(TURN - 1);
    localparam bit            PREEMPT_EN = (MAXHOLD != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    state_t          state_reg,   state_next;
    logic            tr_reg,      tr_next;
    logic            prio_reg,    prio_next;     // 1 = A side has priority
    logic            holder_reg,  holder_next;   // 1 = A side owns the bus
    logic [3:0]      turncnt_reg, turncnt_next;
    logic [HW-1:0]   holdcnt_reg, holdcnt_next;
    logic            cd_reg,      cd_next;
    logic            gnta_reg,    gnta_next;
    logic            gntb_reg,    gntb_next;
    logic            busy_reg,    busy_next;

    logic winner_a;
    logic holder_req;
    logic other_req;

    assign winner_a   = bus.reqa & (~bus.reqb | prio_reg);
    assign holder_req = holder_reg ? bus.reqa : bus.reqb;
    assign other_req  = holder_reg ? bus.reqb : bus.reqa;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tr_reg      <= 1'b0;
            prio_reg    <= 1'b1;
            holder_reg  <= 1'b0;
            turncnt_reg <= '0;
            holdcnt_reg <= '0;
            cd_reg      <= 1'b1;
            gnta_reg    <= 1'b0;
            gntb_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tr_reg      <= tr_next;
            prio_reg    <= prio_next;
            holder_reg  <= holder_next;
            turncnt_reg <= turncnt_next;
            holdcnt_reg <= holdcnt_next;
            cd_reg      <= cd_next;
            gnta_reg    <= gnta_next;
            gntb_reg    <= gntb_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tr_next      = tr_reg;
        prio_next    = prio_reg;
        holder_next  = holder_reg;
        turncnt_next = turncnt_reg;
        holdcnt_next = holdcnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.reqa || bus.reqb) begin
                    holder_next  = winner_a;
                    holdcnt_next = '0;
                    if (winner_a == tr_reg) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        // Direction flips here, while cd is still asserted.
                        state_next   = ST_TURN;
                        tr_next      = winner_a;
                        turncnt_next = TURN_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (turncnt_reg == 4'd0) begin
                    state_next   = ST_ACTIVE;
                    holdcnt_next = '0;
                end else begin
                    turncnt_next = turncnt_reg - 4'd1;
                end
            end
            ST_ACTIVE: begin
                if (!holder_req) begin
                    state_next = ST_DRAIN;
                end else if (PREEMPT_EN && other_req &&
                             (holdcnt_reg == HOLD_LAST || holdcnt_reg == HOLD_SAT)) begin
                    state_next = ST_DRAIN;
                end else if (holdcnt_reg != HOLD_SAT) begin
                    holdcnt_next = holdcnt_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                prio_next  = ~holder_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered images of the next state.
        cd_next   = (state_next != ST_ACTIVE);
        gnta_next = (state_next == ST_ACTIVE) &  holder_next;
        gntb_next = (state_next == ST_ACTIVE) & ~holder_next;
        busy_next = (state_next != ST_IDLE);
    end

    assign bus.cd   = cd_reg;
    assign bus.tr_  = tr_reg;
    assign bus.gnta = gnta_reg;
    assign bus.gntb = gntb_reg;
    assign bus.busy = busy_reg;

endmodule

// File: doc/am2946_ctl.md
# am2946_ctl

Direction and ownership controller for an inverting bus transceiver pair (cd/tr_ style) shared between an A-side and a B-side bus master. It arbitrates the two transfer requests and drives cd and tr_ so that tr_ only changes while the transceiver is disabled. A programmable dead time separates opposite-direction transfers, and a hold limit bounds bus ownership when the other side is waiting. It sits beside the transceiver bank and replaces ad-hoc glue logic.

## Interface
- TURN, 2: dead cycles (cd=1) inserted when direction changes; legal range 1..15
- MAXHOLD, 16: max ACTIVE cycles while the other side is requesting; 0 = unlimited
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- reqa  in  1  A-side master requests A->B transfer (tr_=1)
- reqb  in  1  B-side master requests B->A transfer (tr_=0)
- gnta  out  1  A owns bus, transceiver enabled A->B
- gntb  out  1  B owns bus, transceiver enabled B->A
- cd  out  1  transceiver disable to am2946 cd (1 = both sides Z)
- tr_  out  1  transceiver direction to am2946 tr_ (1 = A->B, 0 = B->A)
- busy  out  1  state != IDLE

## Operation
- All outputs registered. States: IDLE, TURN, ACTIVE, DRAIN.
- Reset (async, immediate): IDLE, cd=1, tr_=0, gnta=0, gntb=0, busy=0, prio=A, holdcnt=0, turncnt=0.
- IDLE:
  - No req: stay.
  - One req: that side wins.
  - Both: side indicated by prio wins.
  - Winner direction equals current tr_: go to ACTIVE.
  - Otherwise: go to TURN with tr_ loaded with the new direction and turncnt=TURN-1.
- TURN: cd=1, gnt=0, tr_ already new value.
  - turncnt==0: go to ACTIVE.
  - Else: decrement turncnt.
  - Requests are not re-sampled. If the winner drops req during TURN, still enter ACTIVE, then release per ACTIVE rules.
- ACTIVE: cd=0, holder's gnt=1, holdcnt cleared on entry, increments, saturates at MAXHOLD.
  - Holder's req low at an edge: go to DRAIN.
  - MAXHOLD!=0, other req high and holdcnt==MAXHOLD-1 or saturated: go to DRAIN (preempt).
  - Other side idle: grant continues indefinitely.
- DRAIN: one cycle, cd=1, gnt=0, tr_ unchanged; prio set to the non-holder; next IDLE.
- Invariants:
  - gnta&gntb never both 1.
  - cd=1 in every cycle where tr_ differs from the previous cycle.
  - cd=0 only in ACTIVE.
  - gnta implies tr_=1, gntb implies tr_=0.
- Counters: turncnt 4 bits; holdcnt width clog2(MAXHOLD+1), min 1.

## Timing
- Same-direction grant: req sampled high at edge k, gnt=1 and cd=0 after edge k (1-cycle latency).
- Direction change: tr_ toggles after edge k, cd=1 for TURN cycles, gnt=1 and cd=0 after edge k+TURN.
- Release: req low sampled at edge m, gnt=0 and cd=1 after edge m, IDLE after m+1. Earliest next grant after edge m+2.
- Preemption: holder gets exactly MAXHOLD ACTIVE cycles when the other side waits the whole time.
- Simultaneous reqa/reqb in IDLE: prio decides; prio flips only in DRAIN, giving round-robin under contention.
- Async rst mid-ACTIVE: cd=1, gnt=0, tr_=0 before the next edge; deassertion then IDLE.

## Test plan
- Reset with reqa=1 held: outputs stay at reset values while rst=1. After release, cd=1 for TURN=2 cycles with tr_=1, then gnta=1, cd=0.
- reqb alone from reset (tr_=0): gntb=1, cd=0 one cycle after first sampling edge, no TURN. Drop reqb: one DRAIN cycle, then IDLE, busy=0.
- reqa and reqb both held, MAXHOLD=4, TURN=2: gnta 4 cycles, DRAIN 1, IDLE 1, TURN 2, gntb 4 cycles, repeat. Check alternation and cd=1 on every tr_ edge.
- MAXHOLD=0, reqa held, reqb asserted mid-grant: gnta persists until reqa drops, then gntb follows after DRAIN, IDLE and 2 TURN cycles.
- reqa pulses one cycle while tr_=0: TURN 2 cycles, one ACTIVE cycle with gnta=1, DRAIN, IDLE.
- rst asserted mid-ACTIVE between edges: cd=1, gnta=0 immediately. Continuously assert that gnta and gntb are never both high.
